// File: rtl/fill_sequencer.sv
// -----------------------------------------------------------------------------
// fill_sequencer
//
// Batch controller for a pill-bottling station running from a 1 kHz tick.
// A batch moves one bottle at a time through INDEX (conveyor brings a bottle
// under the chute), FILL (gate open, pills counted), SETTLE (gate closed while
// the last pills drop), and ADVANCE (bottle counted). It then returns to INDEX
// for the next bottle, or goes to DONE when the batch is complete. Emergency
// stop, conveyor jam and hopper starvation all divert to ERROR. ERROR holds
// until the operator acknowledges it.
//
// Ports
//   clk_1khz          system clock
//   switch_clr        asynchronous active-low reset
//   start             one-cycle batch request (honoured in IDLE/DONE only)
//   clear_err         one-cycle error acknowledge (honoured with estop released)
//   target_pills      pills per bottle, 1..999, latched on start
//   target_bottles    bottles per batch, 1..99, latched on start
//   pill_pulse        one-cycle pulse per pill dropped (already synchronised)
//   bottle_at_station level, bottle under the chute
//   emergency_stop    level, active-high
//   hopper_empty      level, active-high
//   hopper_gate       chute gate open
//   conveyor_run      conveyor motor on
//   pills_cnt         pills in the current bottle
//   bottles_cnt       bottles completed in this batch
//   seq_state         IDLE=0 INDEX=1 FILL=2 SETTLE=3 ADVANCE=4 DONE=5 ERROR=6
//   done              high in DONE
//   err_code          0 none, 1 estop, 2 jam, 3 hopper empty
// -----------------------------------------------------------------------------
module fill_sequencer #(
    parameter int INDEX_TIMEOUT = 3000,
    parameter int SETTLE_CYCLES = 200,
    parameter int EMPTY_TIMEOUT = 5000
) (
    input  logic       clk_1khz,
    input  logic       switch_clr,
    input  logic       start,
    input  logic       clear_err,
    input  logic [9:0] target_pills,
    input  logic [6:0] target_bottles,
    input  logic       pill_pulse,
    input  logic       bottle_at_station,
    input  logic       emergency_stop,
    input  logic       hopper_empty,
    output logic       hopper_gate,
    output logic       conveyor_run,
    output logic [9:0] pills_cnt,
    output logic [6:0] bottles_cnt,
    output logic [2:0] seq_state,
    output logic       done,
    output logic [1:0] err_code
);

    // Cycles at the start of a follow-on INDEX during which the bottle sensor
    // is masked, so the bottle just filled is not detected again.
    localparam int IGNORE_CYCLES = 10;

    localparam int MAX_AB    = (INDEX_TIMEOUT > SETTLE_CYCLES) ? INDEX_TIMEOUT : SETTLE_CYCLES;
    localparam int MAX_ABC   = (MAX_AB > EMPTY_TIMEOUT) ? MAX_AB : EMPTY_TIMEOUT;
    localparam int TIMER_MAX = (MAX_ABC > IGNORE_CYCLES) ? MAX_ABC : IGNORE_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    // The timer holds the number of cycles already spent, so a limit of N is
    // reached on the cycle where the timer reads N-1.
    localparam logic [TIMER_W-1:0] INDEX_LAST  = TIMER_W'(INDEX_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] EMPTY_LAST  = TIMER_W'(EMPTY_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] IGNORE_END  = TIMER_W'(IGNORE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INDEX   = 3'd1,
        S_FILL    = 3'd2,
        S_SETTLE  = 3'd3,
        S_ADVANCE = 3'd4,
        S_DONE    = 3'd5,
        S_ERROR   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ESTOP = 2'd1,
        ERR_JAM   = 2'd2,
        ERR_EMPTY = 2'd3
    } err_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d, timer_inc;
    logic [9:0]         tgt_pills_q, tgt_pills_d;
    logic [6:0]         tgt_bottles_q, tgt_bottles_d;
    logic [9:0]         pills_d;
    logic [6:0]         bottles_d;
    err_t               err_q, err_d;
    logic               gate_d, conveyor_d, done_d;
    logic [9:0]         pills_plus1;
    logic [6:0]         bottles_plus1;
    logic               bottle_seen;

    assign timer_inc     = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + 1'b1;
    assign pills_plus1   = pills_cnt + 10'd1;
    assign bottles_plus1 = bottles_cnt + 7'd1;

    // A non-zero bottle count means this INDEX follows an ADVANCE, i.e. the
    // filled bottle is still leaving the station; the first INDEX of a batch
    // accepts the sensor immediately.
    assign bottle_seen = bottle_at_station &&
                         ((bottles_cnt == 7'd0) || (timer_q >= IGNORE_END));

    always_comb begin
        // NOTE: every variable gets a default before the case so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        timer_d       = timer_q;
        tgt_pills_d   = tgt_pills_q;
        tgt_bottles_d = tgt_bottles_q;
        pills_d       = pills_cnt;
        bottles_d     = bottles_cnt;
        err_d         = err_q;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start && (target_pills != 10'd0) && (target_bottles != 7'd0)) begin
                    tgt_pills_d   = target_pills;
                    tgt_bottles_d = target_bottles;
                    pills_d       = 10'd0;
                    bottles_d     = 7'd0;
                    state_d       = S_INDEX;
                end
            end

            S_INDEX: begin
                if (emergency_stop) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ESTOP;
                end else if (bottle_seen) begin
                    pills_d = 10'd0;
                    state_d = S_FILL;
                end else if (timer_q >= INDEX_LAST) begin
                    state_d = S_ERROR;
                    err_d   = ERR_JAM;
                end else begin
                    timer_d = timer_inc;
                end
            end

            S_FILL: begin
                if (emergency_stop) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ESTOP;
                end else if (pill_pulse && (pills_plus1 == tgt_pills_q)) begin
                    pills_d = pills_plus1;
                    state_d = S_SETTLE;
                end else begin
                    if (pill_pulse) begin
                        pills_d = pills_plus1;
                    end
                    // The timer measures consecutive empty cycles only.
                    if (!hopper_empty) begin
                        timer_d = '0;
                    end else if (timer_q >= EMPTY_LAST) begin
                        state_d = S_ERROR;
                        err_d   = ERR_EMPTY;
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end

            S_SETTLE: begin
                if (emergency_stop) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ESTOP;
                end else if (timer_q >= SETTLE_LAST) begin
                    state_d = S_ADVANCE;
                end else begin
                    timer_d = timer_inc;
                end
            end

            S_ADVANCE: begin
                if (emergency_stop) begin
                    state_d = S_ERROR;
                    err_d   = ERR_ESTOP;
                end else begin
                    bottles_d = bottles_plus1;
                    state_d   = (bottles_plus1 == tgt_bottles_q) ? S_DONE : S_INDEX;
                end
            end

            S_ERROR: begin
                if (clear_err && !emergency_stop) begin
                    err_d     = ERR_NONE;
                    pills_d   = 10'd0;
                    bottles_d = 7'd0;
                    state_d   = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            timer_d = '0;
        end

        // Outputs are derived from the next state so the registered versions
        // change on the same edge as the state itself.
        gate_d     = (state_d == S_FILL) && !hopper_empty;
        conveyor_d = (state_d == S_INDEX);
        done_d     = (state_d == S_DONE);
    end

    always_ff @(posedge clk_1khz or negedge switch_clr) begin
        if (!switch_clr) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            tgt_pills_q   <= 10'd0;
            tgt_bottles_q <= 7'd0;
            pills_cnt     <= 10'd0;
            bottles_cnt   <= 7'd0;
            err_q         <= ERR_NONE;
            hopper_gate   <= 1'b0;
            conveyor_run  <= 1'b0;
            done          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values computed above, independent of statement order.
            state_q       <= state_d;
            timer_q       <= timer_d;
            tgt_pills_q   <= tgt_pills_d;
            tgt_bottles_q <= tgt_bottles_d;
            pills_cnt     <= pills_d;
            bottles_cnt   <= bottles_d;
            err_q         <= err_d;
            hopper_gate   <= gate_d;
            conveyor_run  <= conveyor_d;
            done          <= done_d;
        end
    end

    assign seq_state = state_q;
    assign err_code  = err_q;

endmodule

// File: tb/tb_fill_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fill_sequencer
//
// Scoreboard bench for fill_sequencer. The stimulus process queues the
// expected output tuple for every visible change it provokes, optionally with
// the exact clock count at which the change must appear. A monitor samples the
// outputs on every falling edge and, whenever the tuple changes, pops and
// compares the next expectation. Any change with nothing queued is a failure,
// as is anything still queued at the end.
// -----------------------------------------------------------------------------
module tb_fill_sequencer;

    localparam int INDEX_TIMEOUT = 3000;
    localparam int SETTLE_CYCLES = 200;
    localparam int EMPTY_TIMEOUT = 5000;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INDEX   = 3'd1;
    localparam logic [2:0] ST_FILL    = 3'd2;
    localparam logic [2:0] ST_SETTLE  = 3'd3;
    localparam logic [2:0] ST_ADVANCE = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
    localparam logic [2:0] ST_ERROR   = 3'd6;

    logic       clk_1khz;
    logic       switch_clr;
    logic       start;
    logic       clear_err;
    logic [9:0] target_pills;
    logic [6:0] target_bottles;
    logic       pill_pulse;
    logic       bottle_at_station;
    logic       emergency_stop;
    logic       hopper_empty;
    logic       hopper_gate;
    logic       conveyor_run;
    logic [9:0] pills_cnt;
    logic [6:0] bottles_cnt;
    logic [2:0] seq_state;
    logic       done;
    logic [1:0] err_code;

    fill_sequencer #(
        .INDEX_TIMEOUT(INDEX_TIMEOUT),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .EMPTY_TIMEOUT(EMPTY_TIMEOUT)
    ) dut (
        .clk_1khz          (clk_1khz),
        .switch_clr        (switch_clr),
        .start             (start),
        .clear_err         (clear_err),
        .target_pills      (target_pills),
        .target_bottles    (target_bottles),
        .pill_pulse        (pill_pulse),
        .bottle_at_station (bottle_at_station),
        .emergency_stop    (emergency_stop),
        .hopper_empty      (hopper_empty),
        .hopper_gate       (hopper_gate),
        .conveyor_run      (conveyor_run),
        .pills_cnt         (pills_cnt),
        .bottles_cnt       (bottles_cnt),
        .seq_state         (seq_state),
        .done              (done),
        .err_code          (err_code)
    );

    initial clk_1khz = 1'b0;
    always #5 clk_1khz = ~clk_1khz;

    // Rising-edge counter; a change caused by edge k is seen with cyc == k.
    int cyc = 0;
    always @(posedge clk_1khz) cyc <= cyc + 1;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic       gate;
        logic       conv;
        logic [9:0] pills;
        logic [6:0] bottles;
        logic       dn;
        logic [1:0] err;
        int         at;     // -1: any cycle
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic push(input string name, input logic [2:0] st, input logic gate,
                        input logic conv, input logic [9:0] pills,
                        input logic [6:0] bottles, input logic dn,
                        input logic [1:0] err, input int at);
        exp_t e;
        e.name = name; e.st = st; e.gate = gate; e.conv = conv; e.pills = pills;
        e.bottles = bottles; e.dn = dn; e.err = err; e.at = at;
        exp_q.push_back(e);
    endtask

    // ---------------------------------------------------------------- monitor
    logic [24:0] prev_snap;
    bit          first_sample = 1'b1;

    task automatic monitor_sample();
        logic [24:0] snap;
        logic [24:0] want;
        exp_t        e;
        snap = {seq_state, hopper_gate, conveyor_run, pills_cnt, bottles_cnt, done, err_code};
        if (first_sample || (snap !== prev_snap)) begin
            first_sample = 1'b0;
            prev_snap    = snap;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_change @cyc %0d: st=%0d gate=%0b conv=%0b pills=%0d bottles=%0d done=%0b err=%0d (nothing expected)",
                         cyc, seq_state, hopper_gate, conveyor_run, pills_cnt, bottles_cnt, done, err_code);
            end else begin
                e    = exp_q.pop_front();
                want = {e.st, e.gate, e.conv, e.pills, e.bottles, e.dn, e.err};
                if ((snap !== want) || ((e.at >= 0) && (cyc != e.at))) begin
                    n_bad++;
                    $display("FAIL %s: got st=%0d gate=%0b conv=%0b pills=%0d bottles=%0d done=%0b err=%0d cyc=%0d, want st=%0d gate=%0b conv=%0b pills=%0d bottles=%0d done=%0b err=%0d cyc=%0d",
                             e.name, seq_state, hopper_gate, conveyor_run, pills_cnt, bottles_cnt, done, err_code, cyc,
                             e.st, e.gate, e.conv, e.pills, e.bottles, e.dn, e.err, e.at);
                end
            end
        end
    endtask

    always @(negedge clk_1khz) monitor_sample();

    // -------------------------------------------------------------- stimulus
    task automatic step();
        @(negedge clk_1khz);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) step();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1; step(); clear_err = 1'b0;
    endtask

    task automatic pill();
        pill_pulse = 1'b1; step(); pill_pulse = 1'b0;
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit hit with %0d expectations pending", exp_q.size());
        n_bad++;
        summary();
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        switch_clr = 1'b0; start = 1'b0; clear_err = 1'b0;
        target_pills = 10'd0; target_bottles = 7'd0; pill_pulse = 1'b0;
        bottle_at_station = 1'b0; emergency_stop = 1'b0; hopper_empty = 1'b0;

        push("reset_state", ST_IDLE, 0, 0, 0, 0, 0, 0, -1);
        step(); step();
        switch_clr = 1'b1;
        step();

        // ---------------- normal batch 3 pills x 2 bottles
        target_pills = 10'd3; target_bottles = 7'd2;
        push("nb_index", ST_INDEX, 0, 1, 0, 0, 0, 0, cyc + 1);
        pulse_start();
        target_pills = 10'd5; target_bottles = 7'd7;   // must not matter now
        repeat (4) step();
        bottle_at_station = 1'b1;
        push("nb_fill1", ST_FILL, 1, 0, 0, 0, 0, 0, cyc + 1);
        step();
        for (int p = 1; p <= 2; p++) begin
            push("nb_pill_b1", ST_FILL, 1, 0, 10'(p), 0, 0, 0, cyc + 1);
            pill(); step();
        end
        t = cyc + 1;
        push("nb_settle1", ST_SETTLE, 0, 0, 3, 0, 0, 0, t);
        pill();
        push("nb_advance1", ST_ADVANCE, 0, 0, 3, 0, 0, 0, t + SETTLE_CYCLES);
        push("nb_index2", ST_INDEX, 0, 1, 3, 1, 0, 0, t + SETTLE_CYCLES + 1);
        // Bottle sensor stays high: masked for 10 cycles, taken on the 11th.
        t = t + SETTLE_CYCLES + 1 + 11;
        push("nb_fill2", ST_FILL, 1, 0, 0, 1, 0, 0, t);
        wait_until(t);
        for (int p = 1; p <= 2; p++) begin
            push("nb_pill_b2", ST_FILL, 1, 0, 10'(p), 1, 0, 0, cyc + 1);
            pill(); step();
        end
        t = cyc + 1;
        push("nb_settle2", ST_SETTLE, 0, 0, 3, 1, 0, 0, t);
        pill();
        push("nb_advance2", ST_ADVANCE, 0, 0, 3, 1, 0, 0, t + SETTLE_CYCLES);
        push("nb_done", ST_DONE, 0, 0, 3, 2, 1, 0, t + SETTLE_CYCLES + 1);
        wait_until(t + SETTLE_CYCLES + 1);
        bottle_at_station = 1'b0;

        // DONE holds through estop and an invalid start.
        emergency_stop = 1'b1; repeat (3) step(); emergency_stop = 1'b0;
        target_pills = 10'd0; target_bottles = 7'd2;
        pulse_start(); step();

        // ---------------- jam
        target_pills = 10'd2; target_bottles = 7'd1;
        t = cyc + 1;
        push("jam_index", ST_INDEX, 0, 1, 0, 0, 0, 0, t);
        pulse_start();
        push("jam_error", ST_ERROR, 0, 0, 0, 0, 0, 2, t + INDEX_TIMEOUT);
        wait_until(t + INDEX_TIMEOUT);
        repeat (3) step();
        push("jam_clear", ST_IDLE, 0, 0, 0, 0, 0, 0, cyc + 1);
        pulse_clear(); step();

        // ---------------- invalid starts, estop and pills in IDLE
        target_pills = 10'd0; target_bottles = 7'd3; pulse_start(); step();
        target_pills = 10'd4; target_bottles = 7'd0; pulse_start(); step();
        emergency_stop = 1'b1; repeat (3) step(); emergency_stop = 1'b0;
        pill(); step();

        // ---------------- hopper empty
        target_pills = 10'd2; target_bottles = 7'd1;
        push("he_index", ST_INDEX, 0, 1, 0, 0, 0, 0, cyc + 1);
        pulse_start();
        bottle_at_station = 1'b1;
        push("he_fill", ST_FILL, 1, 0, 0, 0, 0, 0, cyc + 1);
        step();
        push("he_pill1", ST_FILL, 1, 0, 1, 0, 0, 0, cyc + 1);
        pill(); step();
        hopper_empty = 1'b1;
        push("he_gate_shut", ST_FILL, 0, 0, 1, 0, 0, 0, cyc + 1);
        repeat (100) step();
        hopper_empty = 1'b0;
        push("he_gate_reopen", ST_FILL, 1, 0, 1, 0, 0, 0, cyc + 1);
        step(); step();
        hopper_empty = 1'b1;
        t = cyc + 1;
        push("he_gate_shut2", ST_FILL, 0, 0, 1, 0, 0, 0, t);
        push("he_error", ST_ERROR, 0, 0, 1, 0, 0, 3, t + EMPTY_TIMEOUT - 1);
        wait_until(t + EMPTY_TIMEOUT - 1);
        hopper_empty = 1'b0;
        step();
        push("he_clear", ST_IDLE, 0, 0, 0, 0, 0, 0, cyc + 1);
        pulse_clear(); step();

        // ---------------- estop with simultaneous pill
        bottle_at_station = 1'b0;
        target_pills = 10'd3; target_bottles = 7'd1;
        push("es_index", ST_INDEX, 0, 1, 0, 0, 0, 0, cyc + 1);
        pulse_start();
        pill(); step();                              // ignored outside FILL
        bottle_at_station = 1'b1;
        push("es_fill", ST_FILL, 1, 0, 0, 0, 0, 0, cyc + 1);
        step();
        push("es_pill1", ST_FILL, 1, 0, 1, 0, 0, 0, cyc + 1);
        pill(); step();
        pulse_start(); step();                       // ignored during FILL
        emergency_stop = 1'b1; pill_pulse = 1'b1;
        push("es_error", ST_ERROR, 0, 0, 1, 0, 0, 1, cyc + 1);
        step();
        pill_pulse = 1'b0;
        pulse_clear(); repeat (3) step();            // ignored while estop held
        emergency_stop = 1'b0;
        step();
        push("es_clear", ST_IDLE, 0, 0, 0, 0, 0, 0, cyc + 1);
        pulse_clear(); step();

        // ---------------- reset mid-batch during SETTLE of bottle 1
        bottle_at_station = 1'b0;
        target_pills = 10'd1; target_bottles = 7'd2;
        push("rs_index", ST_INDEX, 0, 1, 0, 0, 0, 0, cyc + 1);
        pulse_start();
        bottle_at_station = 1'b1;
        push("rs_fill", ST_FILL, 1, 0, 0, 0, 0, 0, cyc + 1);
        step();
        push("rs_settle", ST_SETTLE, 0, 0, 1, 0, 0, 0, cyc + 1);
        pill();
        repeat (20) step();
        @(posedge clk_1khz);
        #2;
        push("rs_async_clear", ST_IDLE, 0, 0, 0, 0, 0, 0, cyc);
        switch_clr = 1'b0;
        #2;
        switch_clr = 1'b1;
        step();
        for (int i = 0; i < 30; i++) begin            // IDLE must persist
            pill_pulse = (i % 3 == 0);
            step();
        end
        pill_pulse = 1'b0;

        // ---------------- fresh single-bottle batch after reset
        target_pills = 10'd1; target_bottles = 7'd1;
        push("rs2_index", ST_INDEX, 0, 1, 0, 0, 0, 0, cyc + 1);
        pulse_start();
        push("rs2_fill", ST_FILL, 1, 0, 0, 0, 0, 0, cyc + 1);
        step();
        t = cyc + 1;
        push("rs2_settle", ST_SETTLE, 0, 0, 1, 0, 0, 0, t);
        pill();
        push("rs2_advance", ST_ADVANCE, 0, 0, 1, 0, 0, 0, t + SETTLE_CYCLES);
        push("rs2_done", ST_DONE, 0, 0, 1, 1, 1, 0, t + SETTLE_CYCLES + 1);
        wait_until(t + SETTLE_CYCLES + 1);
        repeat (5) step();

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_expectations: got %0d still queued, want 0 (next: %s)",
                     exp_q.size(), exp_q[0].name);
        end

        summary();
        $finish;
    end

endmodule
